// File: rtl/amp_seq_if.sv
// amp_seq_if: power/mute sequencer for NAMP amplifiers with a gated pass-through of NDL I2S data lines.
// Latency: control outputs are registered (1 cycle); amp_nerror adds 2 sync cycles; I2S outputs are input AND gate.
// Backpressure: none; cfg_req is a level held until cfg_done, cfg_err or the config timeout.
module amp_seq_if #(
  parameter int NAMP      = 2,
  parameter int NDL       = 1,
  parameter int CNT_W     = 16,
  parameter int T_EN      = 1000,
  parameter int T_CFG_TO  = 50000,
  parameter int T_MUTE    = 256,
  parameter int T_RETRY   = 4096,
  parameter int MAX_RETRY = 3
) (
  input  logic            clk,
  input  logic            resetb,
  input  logic            ena,
  input  logic [NAMP-1:0] amp_mask,
  input  logic            audio_locked,
  input  logic            i2s_bck_in,
  input  logic            i2s_ws_in,
  input  logic [NDL-1:0]  i2s_d_in,
  input  logic [NAMP-1:0] amp_nerror,
  input  logic            cfg_done,
  input  logic            cfg_err,
  output logic            cfg_req,
  output logic [NAMP-1:0] amp_nenable,
  output logic [NAMP-1:0] amp_nmute,
  output logic            i2s_bck_out,
  output logic            i2s_ws_out,
  output logic [NDL-1:0]  i2s_d_out,
  output logic [NAMP-1:0] fault_flags,
  output logic [1:0]      retry_cnt,
  output logic [2:0]      state_out
);

  typedef enum logic [2:0] {
    S_OFF        = 3'd0,
    S_EN_WAIT    = 3'd1,
    S_CONFIG     = 3'd2,
    S_UNMUTE     = 3'd3,
    S_RUN        = 3'd4,
    S_MUTE_DRAIN = 3'd5,
    S_FAULT_HOLD = 3'd6,
    S_LOCKOUT    = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(T_EN - 1);
  localparam logic [CNT_W-1:0] CFG_TO     = CNT_W'(T_CFG_TO);
  localparam logic [CNT_W-1:0] MUTE_TO    = CNT_W'(T_MUTE);
  localparam logic [CNT_W-1:0] RETRY_LAST = CNT_W'(T_RETRY - 1);
  localparam logic [1:0]       RETRY_MAX  = 2'(MAX_RETRY);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  timer, timer_nxt;
  logic              gate, gate_nxt, cfg_req_nxt;
  logic [NAMP-1:0]   mask_q, mask_nxt, nen_nxt, nmute_nxt, flags_nxt;
  logic [1:0]        retry_nxt, retry_inc;
  logic [NAMP-1:0]   nerr_s1, nerr_s2, amp_fault_vec;
  logic              ws_q, ws_rise, monitored, cfg_fault, fault, shut;
  logic              start, en_done, drain_done, hold_done;

  assign ws_rise       = ~ws_q & i2s_ws_in;
  assign monitored     = state inside {S_CONFIG, S_UNMUTE, S_RUN, S_MUTE_DRAIN};
  assign amp_fault_vec = monitored ? (~nerr_s2 & mask_q) : '0;
  assign cfg_fault     = (state == S_CONFIG) && (cfg_err || timer == CFG_TO);
  assign fault         = (|amp_fault_vec) | cfg_fault;
  assign retry_inc     = (retry_cnt == 2'b11) ? 2'b11 : retry_cnt + 2'd1;
  // RUN and MUTE_DRAIN handle ena low through the frame-aligned drain instead.
  assign shut          = !ena && state != S_RUN && state != S_MUTE_DRAIN;
  assign start         = ena && audio_locked && (|amp_mask);
  assign en_done       = (timer == EN_LAST);
  assign drain_done    = ws_rise || (timer == MUTE_TO);
  assign hold_done     = (timer == RETRY_LAST);

  assign i2s_bck_out = i2s_bck_in & gate;
  assign i2s_ws_out  = i2s_ws_in & gate;
  assign i2s_d_out   = i2s_d_in & {NDL{gate}};
  assign state_out   = state;

  // Two-flop synchroniser for the fault pins plus the WS history for edge detection.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      nerr_s1 <= '1;
      nerr_s2 <= '1;
      ws_q    <= 1'b0;
    end else begin
      nerr_s1 <= amp_nerror;
      nerr_s2 <= nerr_s1;
      ws_q    <= i2s_ws_in;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) state <= S_OFF;
    else         state <= state_nxt;
  end

  // Next state: fault beats ena low, which beats lock loss, ws_rise and timers.
  always_comb begin
    state_nxt = state;
    if (fault) begin
      state_nxt = (retry_inc == RETRY_MAX) ? S_LOCKOUT : S_FAULT_HOLD;
    end else if (shut) begin
      state_nxt = S_OFF;
    end else begin
      case (state)
        S_OFF:        if (start) state_nxt = S_EN_WAIT;
        S_EN_WAIT:    if (en_done) state_nxt = S_CONFIG;
        S_CONFIG:     if (cfg_done) state_nxt = S_UNMUTE;
        S_UNMUTE:     if (ws_rise) state_nxt = S_RUN;
        S_RUN:        if (!ena || !audio_locked) state_nxt = S_MUTE_DRAIN;
        S_MUTE_DRAIN: if (drain_done) state_nxt = S_OFF;
        S_FAULT_HOLD: if (hold_done) state_nxt = S_OFF;
        default:      state_nxt = state;
      endcase
    end
  end

  // Next values of the registered outputs, timer, latched mask and fault bookkeeping.
  always_comb begin
    gate_nxt    = gate;
    nen_nxt     = amp_nenable;
    nmute_nxt   = amp_nmute;
    cfg_req_nxt = cfg_req;
    timer_nxt   = timer;
    mask_nxt    = mask_q;
    flags_nxt   = fault_flags;
    retry_nxt   = retry_cnt;
    if (fault) begin
      gate_nxt    = 1'b0;
      nmute_nxt   = '0;
      nen_nxt     = '1;
      cfg_req_nxt = 1'b0;
      timer_nxt   = '0;
      flags_nxt   = fault_flags | amp_fault_vec;
      retry_nxt   = retry_inc;
    end else begin
      if (!ena) begin
        flags_nxt = '0;
        retry_nxt = '0;
      end
      if (shut) begin
        gate_nxt    = 1'b0;
        nmute_nxt   = '0;
        nen_nxt     = '1;
        cfg_req_nxt = 1'b0;
        timer_nxt   = '0;
      end else begin
        case (state)
          S_OFF: if (start) begin
            mask_nxt  = amp_mask;
            nen_nxt   = ~amp_mask;
            timer_nxt = '0;
          end
          S_EN_WAIT: begin
            if (en_done) begin
              cfg_req_nxt = 1'b1;
              timer_nxt   = '0;
            end else begin
              timer_nxt = timer + CNT_W'(1);
            end
          end
          S_CONFIG: begin
            if (cfg_done) begin
              cfg_req_nxt = 1'b0;
              timer_nxt   = '0;
            end else begin
              timer_nxt = timer + CNT_W'(1);
            end
          end
          S_UNMUTE: if (ws_rise) begin
            gate_nxt  = 1'b1;
            nmute_nxt = mask_q;
          end
          S_RUN: if (!ena || !audio_locked) timer_nxt = '0;
          S_MUTE_DRAIN: begin
            if (drain_done) begin
              gate_nxt  = 1'b0;
              nmute_nxt = '0;
              nen_nxt   = '1;
              timer_nxt = '0;
            end else begin
              timer_nxt = timer + CNT_W'(1);
            end
          end
          S_FAULT_HOLD: timer_nxt = hold_done ? '0 : timer + CNT_W'(1);
          default: ;
        endcase
      end
    end
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      gate        <= 1'b0;
      amp_nenable <= '1;
      amp_nmute   <= '0;
      cfg_req     <= 1'b0;
      timer       <= '0;
      mask_q      <= '0;
      fault_flags <= '0;
      retry_cnt   <= '0;
    end else begin
      gate        <= gate_nxt;
      amp_nenable <= nen_nxt;
      amp_nmute   <= nmute_nxt;
      cfg_req     <= cfg_req_nxt;
      timer       <= timer_nxt;
      mask_q      <= mask_nxt;
      fault_flags <= flags_nxt;
      retry_cnt   <= retry_nxt;
    end
  end

endmodule

// File: tb/tb_amp_seq_if.sv
// tb_amp_seq_if: bring-up, lock-loss drain, fault/lockout, config errors and async reset of amp_seq_if.
// Latency: checks sample 1 time unit after the rising edge; I2S stimulus changes on the falling edge.
// Backpressure: none; every wait on the design is bounded by a cycle budget.
module tb_amp_seq_if;
  localparam int NAMP = 2;
  localparam int NDL  = 2;

  logic            clk, resetb, ena, audio_locked;
  logic [NAMP-1:0] amp_mask, amp_nerror;
  logic            i2s_bck_in, i2s_ws_in;
  logic [NDL-1:0]  i2s_d_in;
  logic            cfg_done, cfg_err, cfg_req;
  logic [NAMP-1:0] amp_nenable, amp_nmute, fault_flags;
  logic            i2s_bck_out, i2s_ws_out;
  logic [NDL-1:0]  i2s_d_out;
  logic [1:0]      retry_cnt;
  logic [2:0]      state_out;

  int pass_cnt = 0;
  int check_cnt = 0;

  // I2S scoreboard: expected gated outputs pushed when the stimulus is driven.
  logic             sb_on = 1'b0;
  logic             exp_gate = 1'b0;
  logic             ws_stop = 1'b0;
  logic [3:0]       fcnt;
  logic [NDL+1:0]   sb_q[$];

  amp_seq_if #(
    .NAMP(NAMP), .NDL(NDL), .CNT_W(16), .T_EN(8), .T_CFG_TO(40),
    .T_MUTE(16), .T_RETRY(32), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .resetb(resetb), .ena(ena), .amp_mask(amp_mask),
    .audio_locked(audio_locked), .i2s_bck_in(i2s_bck_in), .i2s_ws_in(i2s_ws_in),
    .i2s_d_in(i2s_d_in), .amp_nerror(amp_nerror), .cfg_done(cfg_done),
    .cfg_err(cfg_err), .cfg_req(cfg_req), .amp_nenable(amp_nenable),
    .amp_nmute(amp_nmute), .i2s_bck_out(i2s_bck_out), .i2s_ws_out(i2s_ws_out),
    .i2s_d_out(i2s_d_out), .fault_flags(fault_flags), .retry_cnt(retry_cnt),
    .state_out(state_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // I2S source: bck toggles every cycle, ws period 16 cycles, random data.
  initial begin
    fcnt = '0; i2s_bck_in = 1'b0; i2s_ws_in = 1'b0; i2s_d_in = '0;
    forever begin
      @(negedge clk);
      fcnt = fcnt + 4'd1;
      i2s_bck_in = ~i2s_bck_in;
      i2s_ws_in = ws_stop ? 1'b0 : fcnt[3];
      i2s_d_in = NDL'($urandom);
      if (sb_on) sb_q.push_back({i2s_bck_in, i2s_ws_in, i2s_d_in} & {(NDL+2){exp_gate}});
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic inject(input logic [NAMP-1:0] m);
    amp_nerror = ~m;
    tick(1);
    amp_nerror = '1;
    tick(2);
  endtask

  task automatic do_bring_up(input logic [NAMP-1:0] m);
    int n = 0;
    ena = 1'b1; audio_locked = 1'b1; amp_mask = m;
    while (cfg_req !== 1'b1 && n < 200) begin tick(1); n++; end
    cfg_done = 1'b1; tick(1); cfg_done = 1'b0;
    while (state_out !== 3'd4 && n < 200) begin tick(1); n++; end
    check_cnt++;
    if (state_out !== 3'd4) $display("FAIL bring_up_timeout state=%0d required=4", state_out);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    resetb = 1'b0; ena = 1'b0; audio_locked = 1'b0; amp_mask = '0;
    amp_nerror = '1; cfg_done = 1'b0; cfg_err = 1'b0;
    tick(3);
    check_cnt++; if (state_out !== 3'd0) $display("FAIL reset_state got=%0d exp=0", state_out); else pass_cnt++;
    check_cnt++; if (amp_nenable !== 2'b11) $display("FAIL reset_nenable got=%b exp=11", amp_nenable); else pass_cnt++;
    check_cnt++; if (amp_nmute !== 2'b00) $display("FAIL reset_nmute got=%b exp=00", amp_nmute); else pass_cnt++;
    check_cnt++; if ({cfg_req, fault_flags, retry_cnt} !== 5'b0) $display("FAIL reset_misc got=%b exp=0", {cfg_req, fault_flags, retry_cnt}); else pass_cnt++;
    resetb = 1'b1;
    tick(2);
  endtask

  task automatic test_bring_up;
    logic prev, rise, found, early;
    logic [NDL+1:0] exp_v;
    ena = 1'b1; audio_locked = 1'b1; amp_mask = 2'b11;
    tick(1);
    check_cnt++; if (state_out !== 3'd1 || amp_nenable !== 2'b00) $display("FAIL bringup_enable state=%0d nen=%b exp=1/00", state_out, amp_nenable); else pass_cnt++;
    tick(7);
    check_cnt++; if (cfg_req !== 1'b0) $display("FAIL bringup_cfg_early got=%b exp=0", cfg_req); else pass_cnt++;
    tick(1);
    check_cnt++; if (cfg_req !== 1'b1 || state_out !== 3'd2) $display("FAIL bringup_cfg_req req=%b state=%0d exp=1/2", cfg_req, state_out); else pass_cnt++;
    tick(3);
    check_cnt++; if (cfg_req !== 1'b1) $display("FAIL bringup_cfg_hold got=%b exp=1", cfg_req); else pass_cnt++;
    cfg_done = 1'b1; tick(1); cfg_done = 1'b0;
    check_cnt++; if (cfg_req !== 1'b0 || state_out !== 3'd3) $display("FAIL bringup_cfg_done req=%b state=%0d exp=0/3", cfg_req, state_out); else pass_cnt++;
    prev = i2s_ws_in; found = 1'b0; early = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      rise = !prev && i2s_ws_in;
      prev = i2s_ws_in;
      if (rise) begin found = 1'b1; break; end
      if (amp_nmute !== 2'b00 || i2s_bck_out !== 1'b0 || state_out !== 3'd3) early = 1'b1;
    end
    check_cnt++; if (!found || early) $display("FAIL unmute_align found=%b early=%b exp=1/0", found, early); else pass_cnt++;
    check_cnt++; if (amp_nmute !== 2'b11 || state_out !== 3'd4) $display("FAIL unmute_on_rise nmute=%b state=%0d exp=11/4", amp_nmute, state_out); else pass_cnt++;
    exp_gate = 1'b1; sb_on = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      check_cnt++;
      if (sb_q.size() == 0) $display("FAIL i2s_pass cycle=%0d got=empty exp=entry", i);
      else begin
        exp_v = sb_q.pop_front();
        if ({i2s_bck_out, i2s_ws_out, i2s_d_out} !== exp_v) $display("FAIL i2s_pass cycle=%0d got=%b exp=%b", i, {i2s_bck_out, i2s_ws_out, i2s_d_out}, exp_v);
        else pass_cnt++;
      end
    end
    sb_on = 1'b0;
  endtask

  task automatic test_lock_loss;
    logic prev, rise, found, bad;
    audio_locked = 1'b0;
    tick(1);
    check_cnt++; if (state_out !== 3'd5) $display("FAIL drain_enter got=%0d exp=5", state_out); else pass_cnt++;
    prev = i2s_ws_in; found = 1'b0; bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      rise = !prev && i2s_ws_in;
      prev = i2s_ws_in;
      if (rise) begin found = 1'b1; break; end
      if (i2s_d_out !== i2s_d_in || i2s_ws_out !== i2s_ws_in || i2s_bck_out !== i2s_bck_in || state_out !== 3'd5) bad = 1'b1;
    end
    check_cnt++; if (!found || bad) $display("FAIL drain_pass found=%b bad=%b exp=1/0", found, bad); else pass_cnt++;
    check_cnt++; if ({state_out, amp_nmute, amp_nenable} !== {3'd0, 2'b00, 2'b11}) $display("FAIL drain_on_rise got=%b exp=0000011", {state_out, amp_nmute, amp_nenable}); else pass_cnt++;
    check_cnt++; if (i2s_ws_out !== 1'b0) $display("FAIL drain_gate_off ws_out=%b exp=0", i2s_ws_out); else pass_cnt++;
    do_bring_up(2'b11);
    ws_stop = 1'b1;
    tick(2);
    audio_locked = 1'b0;
    tick(1);
    check_cnt++; if (state_out !== 3'd5) $display("FAIL forced_enter got=%0d exp=5", state_out); else pass_cnt++;
    tick(16);
    check_cnt++; if (state_out !== 3'd5 || amp_nmute !== 2'b11) $display("FAIL forced_wait state=%0d nmute=%b exp=5/11", state_out, amp_nmute); else pass_cnt++;
    tick(1);
    check_cnt++; if (state_out !== 3'd0 || amp_nmute !== 2'b00 || amp_nenable !== 2'b11) $display("FAIL forced_mute state=%0d nmute=%b nen=%b exp=0/00/11", state_out, amp_nmute, amp_nenable); else pass_cnt++;
    ws_stop = 1'b0;
  endtask

  task automatic test_fault;
    logic [NDL+1:0] exp_v;
    do_bring_up(2'b11);
    amp_nerror = 2'b01;
    tick(1);
    amp_nerror = 2'b11;
    check_cnt++; if (state_out !== 3'd4 || amp_nmute !== 2'b11) $display("FAIL fault_sync1 state=%0d nmute=%b exp=4/11", state_out, amp_nmute); else pass_cnt++;
    tick(1);
    check_cnt++; if (state_out !== 3'd4) $display("FAIL fault_sync2 state=%0d exp=4", state_out); else pass_cnt++;
    tick(1);
    check_cnt++; if ({state_out, amp_nenable, amp_nmute} !== {3'd6, 2'b11, 2'b00}) $display("FAIL fault_safe got=%b exp=1101100", {state_out, amp_nenable, amp_nmute}); else pass_cnt++;
    check_cnt++; if (fault_flags !== 2'b10 || retry_cnt !== 2'd1) $display("FAIL fault_flags flags=%b retry=%0d exp=10/1", fault_flags, retry_cnt); else pass_cnt++;
    exp_gate = 1'b0; sb_on = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check_cnt++;
      if (sb_q.size() == 0) $display("FAIL i2s_blocked cycle=%0d got=empty exp=entry", i);
      else begin
        exp_v = sb_q.pop_front();
        if ({i2s_bck_out, i2s_ws_out, i2s_d_out} !== exp_v) $display("FAIL i2s_blocked cycle=%0d got=%b exp=%b", i, {i2s_bck_out, i2s_ws_out, i2s_d_out}, exp_v);
        else pass_cnt++;
      end
    end
    sb_on = 1'b0;
    tick(23);
    check_cnt++; if (state_out !== 3'd6) $display("FAIL hold_len state=%0d exp=6", state_out); else pass_cnt++;
    tick(1);
    check_cnt++; if (state_out !== 3'd0) $display("FAIL hold_exit state=%0d exp=0", state_out); else pass_cnt++;
    tick(1);
    check_cnt++; if (state_out !== 3'd1) $display("FAIL hold_rebringup state=%0d exp=1", state_out); else pass_cnt++;
  endtask

  task automatic test_lockout;
    ena = 1'b0;
    tick(1);
    check_cnt++; if ({state_out, retry_cnt, fault_flags} !== 7'b0) $display("FAIL ena_clear got=%b exp=0", {state_out, retry_cnt, fault_flags}); else pass_cnt++;
    do_bring_up(2'b11); inject(2'b01);
    do_bring_up(2'b11); inject(2'b10);
    check_cnt++; if (state_out !== 3'd6 || retry_cnt !== 2'd2) $display("FAIL second_fault state=%0d retry=%0d exp=6/2", state_out, retry_cnt); else pass_cnt++;
    do_bring_up(2'b11); inject(2'b10);
    check_cnt++; if ({state_out, retry_cnt, fault_flags} !== {3'd7, 2'd3, 2'b11}) $display("FAIL lockout_enter got=%b exp=1111111", {state_out, retry_cnt, fault_flags}); else pass_cnt++;
    tick(40);
    check_cnt++; if (state_out !== 3'd7 || amp_nenable !== 2'b11) $display("FAIL lockout_stay state=%0d nen=%b exp=7/11", state_out, amp_nenable); else pass_cnt++;
    ena = 1'b0;
    tick(1);
    check_cnt++; if ({state_out, retry_cnt, fault_flags} !== 7'b0) $display("FAIL lockout_clear got=%b exp=0", {state_out, retry_cnt, fault_flags}); else pass_cnt++;
  endtask

  task automatic test_config;
    int n = 0;
    ena = 1'b1; audio_locked = 1'b1; amp_mask = 2'b11;
    while (cfg_req !== 1'b1 && n < 100) begin tick(1); n++; end
    check_cnt++; if (cfg_req !== 1'b1) $display("FAIL cfg_req_timeout got=%b exp=1", cfg_req); else pass_cnt++;
    cfg_err = 1'b1; tick(1); cfg_err = 1'b0;
    check_cnt++; if ({state_out, cfg_req, retry_cnt, fault_flags, amp_nenable} !== {3'd6, 1'b0, 2'd1, 2'b00, 2'b11}) $display("FAIL cfg_err got=%b exp=1100010011", {state_out, cfg_req, retry_cnt, fault_flags, amp_nenable}); else pass_cnt++;
    n = 0;
    while (cfg_req !== 1'b1 && n < 100) begin tick(1); n++; end
    tick(40);
    check_cnt++; if (state_out !== 3'd2 || cfg_req !== 1'b1) $display("FAIL cfg_to_wait state=%0d req=%b exp=2/1", state_out, cfg_req); else pass_cnt++;
    tick(1);
    check_cnt++; if (state_out !== 3'd6 || retry_cnt !== 2'd2 || cfg_req !== 1'b0) $display("FAIL cfg_timeout state=%0d retry=%0d req=%b exp=6/2/0", state_out, retry_cnt, cfg_req); else pass_cnt++;
    ena = 1'b0; tick(1);
    ena = 1'b1; amp_mask = 2'b01; tick(1);
    check_cnt++; if (state_out !== 3'd1 || amp_nenable !== 2'b10) $display("FAIL mask01_enable state=%0d nen=%b exp=1/10", state_out, amp_nenable); else pass_cnt++;
    do_bring_up(2'b01);
    check_cnt++; if (amp_nmute !== 2'b01 || amp_nenable !== 2'b10) $display("FAIL mask01_run nmute=%b nen=%b exp=01/10", amp_nmute, amp_nenable); else pass_cnt++;
    inject(2'b10);
    check_cnt++; if (state_out !== 3'd4 || retry_cnt !== 2'd0) $display("FAIL mask01_ignore state=%0d retry=%0d exp=4/0", state_out, retry_cnt); else pass_cnt++;
  endtask

  task automatic test_async_reset;
    check_cnt++; if (i2s_ws_out !== i2s_ws_in || state_out !== 3'd4) $display("FAIL pre_reset_run state=%0d exp=4", state_out); else pass_cnt++;
    @(posedge clk);
    #3 resetb = 1'b0;
    #1;
    check_cnt++; if ({state_out, amp_nenable, amp_nmute, cfg_req} !== {3'd0, 2'b11, 2'b00, 1'b0}) $display("FAIL async_reset got=%b exp=00011000", {state_out, amp_nenable, amp_nmute, cfg_req}); else pass_cnt++;
    check_cnt++; if ({i2s_bck_out, i2s_ws_out, i2s_d_out, retry_cnt, fault_flags} !== '0) $display("FAIL async_reset_gate got=%b exp=0", {i2s_bck_out, i2s_ws_out, i2s_d_out, retry_cnt, fault_flags}); else pass_cnt++;
    #2 resetb = 1'b1;
    tick(1);
  endtask

  initial begin
    test_reset();
    test_bring_up();
    test_lock_loss();
    test_fault();
    test_lockout();
    test_config();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
